// File: rtl/mem_io_bridge.sv
// ============================================================================
// Module   : mem_io_bridge
// Purpose  : Bridges control-FSM memory accesses to a registered-output BRAM
//            and a single memory-mapped switch/hex I/O location.
//            Optional access counters are enabled by MEM_IO_ACCESS_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_io_bridge #(
  parameter int          RAM_AW      = 10,
  parameter int          RAM_LATENCY = 2,
  parameter logic [15:0] IO_ADDR     = 16'hFFFF
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [15:0]       mar,
  input  logic [15:0]       mdr,
  input  logic              mem_mem_ena,
  input  logic              mem_wr_ena,
  input  logic [15:0]       sw_i,
  input  logic [15:0]       bram_dout,
  output logic              bram_ena,
  output logic              bram_wea,
  output logic [RAM_AW-1:0] bram_addr,
  output logic [15:0]       bram_din,
  output logic [15:0]       mem_rdata,
  output logic              rd_valid,
  output logic [15:0]       hex_data,
`ifdef MEM_IO_ACCESS_CNT_EN
  output logic [15:0]       rd_cnt,
  output logic [15:0]       wr_cnt,
`endif
  output logic              addr_err
);

  localparam logic [1:0] c_SRC_RAM = 2'd0;
  localparam logic [1:0] c_SRC_IO  = 2'd1;
  localparam logic [1:0] c_SRC_ERR = 2'd2;
  localparam int         c_TAIL    = RAM_LATENCY - 1;

  logic        w_is_io;
  logic        w_is_ram;
  logic        w_wr_req;
  logic        w_rd_req;
  logic        w_first;
  logic [1:0]  w_src;

  logic        r_wr_prev;
  logic [15:0] r_hex;
  logic        r_err;
  logic [15:0] r_sw_meta;
  logic [15:0] r_sw_sync;

  logic        r_vld [RAM_LATENCY];
  logic [1:0]  r_src [RAM_LATENCY];
  logic [15:0] r_sw  [RAM_LATENCY];

  assign w_is_io  = (mar == IO_ADDR);
  assign w_is_ram = ((mar >> RAM_AW) == 16'd0);
  assign w_wr_req = mem_mem_ena & mem_wr_ena;
  assign w_rd_req = mem_mem_ena & ~mem_wr_ena;
  // Only the opening cycle of a write burst commits; reset kills it at once.
  assign w_first  = w_wr_req & ~r_wr_prev & reset_n;

  assign w_src = w_is_io ? c_SRC_IO : (w_is_ram ? c_SRC_RAM : c_SRC_ERR);

  assign bram_addr = mar[RAM_AW-1:0];
  assign bram_din  = mdr;
  assign bram_ena  = mem_mem_ena & w_is_ram;
  assign bram_wea  = w_first & w_is_ram;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_prev <= 1'b0;
      r_hex     <= 16'h0000;
      r_err     <= 1'b0;
      r_sw_meta <= 16'h0000;
      r_sw_sync <= 16'h0000;
    end else begin
      r_wr_prev <= w_wr_req;
      r_sw_meta <= sw_i;
      r_sw_sync <= r_sw_meta;
      if (w_first && w_is_io) begin
        r_hex <= mdr;
      end
      if (mem_mem_ena && !w_is_ram && !w_is_io) begin
        r_err <= 1'b1;
      end
    end
  end

  // Read tag pipeline tracks BRAM latency; switch data rides along for IO reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RAM_LATENCY; i++) begin
        r_vld[i] <= 1'b0;
        r_src[i] <= c_SRC_RAM;
        r_sw[i]  <= 16'h0000;
      end
    end else begin
      r_vld[0] <= w_rd_req;
      r_src[0] <= w_src;
      r_sw[0]  <= r_sw_sync;
      for (int i = 1; i < RAM_LATENCY; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_src[i] <= r_src[i-1];
        r_sw[i]  <= r_sw[i-1];
      end
    end
  end

  assign rd_valid = r_vld[c_TAIL];
  assign hex_data = r_hex;
  assign addr_err = r_err;

  always_comb begin
    mem_rdata = 16'h0000;
    if (r_vld[c_TAIL]) begin
      case (r_src[c_TAIL])
        c_SRC_RAM: mem_rdata = bram_dout;
        c_SRC_IO:  mem_rdata = r_sw[c_TAIL];
        default:   mem_rdata = 16'h0000;
      endcase
    end
  end

`ifdef MEM_IO_ACCESS_CNT_EN
  logic        r_rd_prev;
  logic [15:0] r_rd_cnt;
  logic [15:0] r_wr_cnt;
  logic        w_rd_start;
  logic        w_wr_commit;

  assign w_rd_start  = w_rd_req & ~r_rd_prev;
  assign w_wr_commit = w_first & (w_is_ram | w_is_io);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_prev <= 1'b0;
      r_rd_cnt  <= 16'h0000;
      r_wr_cnt  <= 16'h0000;
    end else begin
      r_rd_prev <= w_rd_req;
      if (w_rd_start && (r_rd_cnt != 16'hFFFF)) begin
        r_rd_cnt <= r_rd_cnt + 16'd1;
      end
      if (w_wr_commit && (r_wr_cnt != 16'hFFFF)) begin
        r_wr_cnt <= r_wr_cnt + 16'd1;
      end
    end
  end

  assign rd_cnt = r_rd_cnt;
  assign wr_cnt = r_wr_cnt;
`endif

endmodule

`default_nettype wire
